equiv_check_sequencer: RTL

- Hardware sequencer for golden-vs-post-route equivalence runs.
- Drives a shared pseudo-random stimulus bus and DUT reset into a golden model and its post-route netlist.
- Waits a programmable settle time per vector, compares the two output buses, and keeps mismatch statistics.
- Replaces per-design bench sequencing with a reusable synthesizable block, so the same check runs in simulation and on an FPGA harness.

---
 rtl/equiv_pkg.sv | 28 ++
 rtl/equiv_lfsr.sv | 32 +++
 rtl/equiv_check_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/equiv_pkg.sv
// Shared types, constants and the LFSR step function for the
// golden-vs-netlist equivalence sequencer.
package equiv_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RST_DUT = 3'd1,
    RST_CMP = 3'd2,
    RELEASE = 3'd3,
    APPLY   = 3'd4,
    SETTLE  = 3'd5,
    COMPARE = 3'd6,
    DONE    = 3'd7
  } state_t;

  // Galois taps for x^32+x^22+x^2+x+1
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // Index recorded for a mismatch seen during the reset-state compare
  // (sliced down to the counter width by the user)
  localparam logic [63:0] CMP_RST_IDX = {64{1'b1}};

  // One right shift of the Galois LFSR; taps fold in when a 1 falls out
  function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_POLY : 32'h0000_0000);
  endfunction

endpackage

// File: rtl/equiv_lfsr.sv
// 32-bit stimulus LFSR: reloads its seed at run start and advances one
// step per applied vector.
module equiv_lfsr
  import equiv_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  output logic [31:0] value
);

  logic [31:0] value_r;

  // Seed on reset or load, otherwise advance only when asked
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_r <= SEED;
    end else if (load) begin
      value_r <= SEED;
    end else if (step) begin
      value_r <= lfsr_next(value_r);
    end else begin
      value_r <= value_r;
    end
  end

  assign value = value_r;

endmodule

// File: rtl/equiv_check_sequencer.sv
// Sequencer that resets two DUT copies, checks their reset state, then
// streams LFSR vectors into both and compares their outputs after a
// settle delay, keeping pass/fail statistics for the run.
module equiv_check_sequencer
  import equiv_pkg::*;
#(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned NUM_VECTORS   = 1000,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned RESET_CYCLES  = 2,
  parameter logic [31:0] LFSR_SEED     = 32'h0000_0001,
  parameter int unsigned CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              dut_rst,
  output logic [DATA_W-1:0] stim,
  input  logic [DATA_W-1:0] golden_out,
  input  logic [DATA_W-1:0] netlist_out,
  output logic              cmp_valid,
  output logic              cmp_match,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              aborted,
  output logic [CNT_W-1:0]  vec_cnt,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic              first_fail_valid,
  output logic [CNT_W-1:0]  first_fail_idx
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] RST_IDX  = CMP_RST_IDX[CNT_W-1:0];

  state_t              state_r, state_step_s, state_s;
  logic [31:0]         wait_r, wait_s;
  logic [31:0]         vec_total_r, vec_total_s;
  logic [CNT_W-1:0]    vec_cnt_r, vec_cnt_s;
  logic [CNT_W-1:0]    mismatch_r, mismatch_s;
  logic                ffv_r, ffv_s;
  logic [CNT_W-1:0]    ffi_r, ffi_s;
  logic                pass_r, pass_step_s, pass_s;
  logic                aborted_r, aborted_step_s, aborted_s;
  logic [DATA_W-1:0]   stim_r, stim_s;
  logic                dut_rst_r, busy_r, done_r, cmp_valid_r;
  logic                dut_rst_s, busy_s, done_s, cmp_valid_s;
  logic                lfsr_load_s, lfsr_step_s, abort_hit_s, match_s;
  logic [31:0]         lfsr_value_s;

  equiv_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load_s),
    .step  (lfsr_step_s),
    .value (lfsr_value_s)
  );

  // Four-state exact equality: any X/Z difference is a mismatch
  assign match_s     = (golden_out === netlist_out);
  assign abort_hit_s = abort & busy_r;

  // Per-state sequencing, counters and compare bookkeeping
  always_comb begin
    state_step_s   = state_r;
    wait_s         = wait_r;
    vec_total_s    = vec_total_r;
    vec_cnt_s      = vec_cnt_r;
    mismatch_s     = mismatch_r;
    ffv_s          = ffv_r;
    ffi_s          = ffi_r;
    pass_step_s    = pass_r;
    aborted_step_s = aborted_r;
    stim_s         = stim_r;
    lfsr_load_s    = 1'b0;
    lfsr_step_s    = 1'b0;
    case (state_r)
      IDLE: begin
        stim_s = {DATA_W{1'b0}};
        if (start) begin
          state_step_s   = RST_DUT;
          wait_s         = RESET_CYCLES;
          vec_total_s    = 32'd0;
          vec_cnt_s      = CNT_ZERO;
          mismatch_s     = CNT_ZERO;
          ffv_s          = 1'b0;
          ffi_s          = CNT_ZERO;
          pass_step_s    = 1'b0;
          aborted_step_s = 1'b0;
          lfsr_load_s    = 1'b1;
        end else begin
          state_step_s = IDLE;
        end
      end
      RST_DUT: begin
        if (wait_r <= 32'd1) begin
          state_step_s = RST_CMP;
        end else begin
          wait_s = wait_r - 32'd1;
        end
      end
      RST_CMP: begin
        state_step_s = RELEASE;
        if (!match_s) begin
          mismatch_s = (mismatch_r != CNT_MAX) ? (mismatch_r + CNT_ONE) : mismatch_r;
          if (!ffv_r) begin
            ffv_s = 1'b1;
            ffi_s = RST_IDX;
          end else begin
            ffi_s = ffi_r;
          end
        end else begin
          mismatch_s = mismatch_r;
        end
      end
      RELEASE: begin
        state_step_s = APPLY;
      end
      APPLY: begin
        stim_s       = DATA_W'(lfsr_value_s);
        lfsr_step_s  = 1'b1;
        wait_s       = SETTLE_CYCLES;
        state_step_s = SETTLE;
      end
      SETTLE: begin
        if (wait_r <= 32'd1) begin
          state_step_s = COMPARE;
        end else begin
          wait_s = wait_r - 32'd1;
        end
      end
      COMPARE: begin
        vec_total_s = vec_total_r + 32'd1;
        vec_cnt_s   = vec_cnt_r + CNT_ONE;
        if (!match_s) begin
          mismatch_s = (mismatch_r != CNT_MAX) ? (mismatch_r + CNT_ONE) : mismatch_r;
          if (!ffv_r) begin
            ffv_s = 1'b1;
            ffi_s = vec_cnt_r;
          end else begin
            ffi_s = ffi_r;
          end
        end else begin
          mismatch_s = mismatch_r;
        end
        if (vec_total_s == NUM_VECTORS) begin
          state_step_s = DONE;
        end else begin
          state_step_s = APPLY;
        end
      end
      DONE: begin
        stim_s       = {DATA_W{1'b0}};
        state_step_s = IDLE;
      end
      default: begin
        state_step_s = IDLE;
      end
    endcase
  end

  // Abort override, run verdict and output decode for the next state
  always_comb begin
    if (abort_hit_s) begin
      state_s   = DONE;
      aborted_s = 1'b1;
    end else begin
      state_s   = state_step_s;
      aborted_s = aborted_step_s;
    end
    if (state_s == DONE) begin
      pass_s = (mismatch_s == CNT_ZERO) && !aborted_s;
    end else begin
      pass_s = pass_step_s;
    end
    dut_rst_s   = (state_s == IDLE) || (state_s == RST_DUT) ||
                  (state_s == RST_CMP) || (state_s == DONE);
    busy_s      = (state_s != IDLE) && (state_s != DONE);
    done_s      = (state_s == DONE);
    cmp_valid_s = (state_s == RST_CMP) || (state_s == COMPARE);
  end

  // State, statistics and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      wait_r      <= 32'd0;
      vec_total_r <= 32'd0;
      vec_cnt_r   <= CNT_ZERO;
      mismatch_r  <= CNT_ZERO;
      ffv_r       <= 1'b0;
      ffi_r       <= CNT_ZERO;
      pass_r      <= 1'b0;
      aborted_r   <= 1'b0;
      stim_r      <= {DATA_W{1'b0}};
      dut_rst_r   <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      cmp_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      wait_r      <= wait_s;
      vec_total_r <= vec_total_s;
      vec_cnt_r   <= vec_cnt_s;
      mismatch_r  <= mismatch_s;
      ffv_r       <= ffv_s;
      ffi_r       <= ffi_s;
      pass_r      <= pass_s;
      aborted_r   <= aborted_s;
      stim_r      <= stim_s;
      dut_rst_r   <= dut_rst_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      cmp_valid_r <= cmp_valid_s;
    end
  end

  assign dut_rst          = dut_rst_r;
  assign stim             = stim_r;
  assign cmp_valid        = cmp_valid_r;
  assign cmp_match        = cmp_valid_r & match_s;
  assign busy             = busy_r;
  assign done             = done_r;
  assign pass             = pass_r;
  assign aborted          = aborted_r;
  assign vec_cnt          = vec_cnt_r;
  assign mismatch_cnt     = mismatch_r;
  assign first_fail_valid = ffv_r;
  assign first_fail_idx   = ffi_r;

endmodule
